// File: rtl/rf_pkg.sv
// Shared defaults and grant encoding for the register-file writeback arbiter.
package rf_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LOAD = 2'd2
    } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: bit 0 = ALU, bit 1 = load; on a tie the
// requester that did not win last time is chosen.
module rr_arb2
    import rf_pkg::*;
(
    input  logic [1:0] i_req,
    input  gnt_e       i_last_gnt,
    output logic [1:0] o_gnt
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last_gnt == GNT_ALU) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load writebacks onto a single register-file write port with
// one holding entry per requester. Define RF_BYPASS_EN to forward the write port to the reads.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              res,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [REG_AW-1:0] l_reg,
    input  logic [DATA_W-1:0] l_data,
    input  logic              flush,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_reg,
    output logic [DATA_W-1:0] data,
    input  logic [REG_AW-1:0] Ra,
    input  logic [REG_AW-1:0] Rb,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    output logic [DATA_W-1:0] fwd_out1,
    output logic [DATA_W-1:0] fwd_out2
);

    logic              r_occ_a, r_occ_l;
    logic [REG_AW-1:0] r_reg_a, r_reg_l;
    logic [DATA_W-1:0] r_data_a, r_data_l;
    gnt_e              r_last;
    logic              r_wr_en;
    logic [REG_AW-1:0] r_wr_reg;
    logic [DATA_W-1:0] r_data;

    logic [1:0] w_arb_gnt;
    logic       w_gnt_a, w_gnt_l;
    logic       w_acc_a, w_acc_l;

    rr_arb2 u_arb (
        .i_req      ({r_occ_l, r_occ_a}),
        .i_last_gnt (r_last),
        .o_gnt      (w_arb_gnt)
    );

    // Flush and reset both suppress the grant so nothing new reaches the port.
    assign w_gnt_a = w_arb_gnt[0] & ~flush & ~res;
    assign w_gnt_l = w_arb_gnt[1] & ~flush & ~res;

    assign a_ready = ~res & ~flush & (~r_occ_a | w_gnt_a);
    assign l_ready = ~res & ~flush & (~r_occ_l | w_gnt_l);
    assign w_acc_a = a_valid & a_ready;
    assign w_acc_l = l_valid & l_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            r_occ_a  <= 1'b0;
            r_occ_l  <= 1'b0;
            r_last   <= GNT_ALU;
            r_wr_en  <= 1'b0;
            r_wr_reg <= '0;
            r_data   <= '0;
        end else begin
            r_wr_en <= w_gnt_a | w_gnt_l;
            if (w_gnt_a) begin
                r_wr_reg <= r_reg_a;
                r_data   <= r_data_a;
                r_last   <= GNT_ALU;
            end else if (w_gnt_l) begin
                r_wr_reg <= r_reg_l;
                r_data   <= r_data_l;
                r_last   <= GNT_LOAD;
            end

            // Writes to r0 are accepted but never occupy the entry.
            if (flush)        r_occ_a <= 1'b0;
            else if (w_acc_a) r_occ_a <= (a_reg != '0);
            else if (w_gnt_a) r_occ_a <= 1'b0;

            if (flush)        r_occ_l <= 1'b0;
            else if (w_acc_l) r_occ_l <= (l_reg != '0);
            else if (w_gnt_l) r_occ_l <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed while the occupied flag is set.
    always_ff @(posedge clk) begin
        if (w_acc_a) begin
            r_reg_a  <= a_reg;
            r_data_a <= a_data;
        end
        if (w_acc_l) begin
            r_reg_l  <= l_reg;
            r_data_l <= l_data;
        end
    end

    assign wr_en  = r_wr_en;
    assign wr_reg = r_wr_reg;
    assign data   = r_data;

`ifdef RF_BYPASS_EN
    assign fwd_out1 = (r_wr_en && r_wr_reg == Ra && Ra != '0) ? r_data : rf_out1;
    assign fwd_out2 = (r_wr_en && r_wr_reg == Rb && Rb != '0) ? r_data : rf_out2;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{Ra, Rb};
    assign fwd_out1    = rf_out1;
    assign fwd_out2    = rf_out2;
`endif

endmodule
